// File: rtl/obstacle_hitbox_gen.sv
// obstacle_hitbox_gen: owns the ground-obstacle slots (spawn at the right edge,
// scroll left once per frame, retire off the left edge and score) and produces
// a registered per-pixel hitbox for the collision detector.
// Optional build macro: OBSTACLE_SPEEDUP_EN (scroll speed grows with score).
module obstacle_hitbox_gen #(
    parameter int NUM_OBS    = 4,
    parameter int SCREEN_W   = 96,
    parameter int SCREEN_H   = 64,
    parameter int OBS_W      = 6,
    parameter int GROUND_Y   = 56,
    parameter int SPAWN_GAP  = 40,
    parameter int BASE_SPEED = 1
) (
    input  logic        clock_100mhz,
    input  logic        reset_n,
    input  logic [12:0] pixel_index,
    input  logic        frame_tick,
    input  logic        game_active,
    input  logic        is_collision,
    output logic        is_obstacle_hitbox,
    output logic [7:0]  score,
    output logic        game_frozen
);
    localparam int                      CNT_W      = $clog2(SPAWN_GAP + 2);
    localparam logic signed [13:0]      OBS_W_C    = 14'(OBS_W);
    localparam logic signed [13:0]      GROUND_C   = 14'(GROUND_Y);
    localparam logic signed [8:0]       SPAWN_X_C  = 9'(SCREEN_W);
    localparam logic [12:0]             SCREEN_W_C = 13'(SCREEN_W);
    localparam logic [12:0]             PIX_MAX_C  = 13'(SCREEN_W * SCREEN_H);
    localparam logic [CNT_W-1:0]        GAP_C      = CNT_W'(SPAWN_GAP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    // 8-bit Fibonacci LFSR step, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        lfsr_next = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Sign-extend a slot x position to the hit-test width.
    function automatic logic signed [13:0] sext9(input logic signed [8:0] v);
        sext9 = {{5{v[8]}}, v};
    endfunction

    state_t                 state_q, state_d;
    logic [NUM_OBS-1:0]     act_q, act_d;
    logic signed [8:0]      x_q [NUM_OBS];
    logic signed [8:0]      x_d [NUM_OBS];
    logic [3:0]             h_q [NUM_OBS];
    logic [3:0]             h_d [NUM_OBS];
    logic [7:0]             score_q, score_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic                   hit_q, hit_d;

    logic signed [8:0]      speed_s;
    logic signed [8:0]      x_mv_s [NUM_OBS];
    logic [NUM_OBS-1:0]     retire_s, free_s, spawn_oh_s, hit_vec_s;
    logic [3:0]             ret_cnt_s;
    logic [8:0]             score_sum_s;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic [3:0]             spawn_h_s;
    logic [12:0]            px_u_s, py_u_s;
    logic signed [13:0]     px_s, py_s;
    logic                   frozen_s;

`ifdef OBSTACLE_SPEEDUP_EN
    logic [1:0]             bump_s;

    // Scroll speed gains one pixel per 8 points of score, at most three extra.
    always_comb begin
        if (score_q[7:3] >= 5'd3) begin
            bump_s = 2'd3;
        end else begin
            bump_s = score_q[4:3];
        end
        speed_s = 9'(BASE_SPEED) + {7'd0, bump_s};
    end
`else
    assign speed_s = 9'(BASE_SPEED);
`endif

    // FSM state register.
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: dropping game_active wins over everything, collision freezes.
    always_comb begin
        state_d = state_q;
        if (!game_active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_RUN;
                ST_RUN:    state_d = is_collision ? ST_FROZEN : ST_RUN;
                ST_FROZEN: state_d = ST_FROZEN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        frozen_s = (state_q == ST_FROZEN);
    end

    // Per-slot motion, retirement count and lowest free slot for this frame.
    always_comb begin
        ret_cnt_s = 4'd0;
        for (int i = 0; i < NUM_OBS; i++) begin
            x_mv_s[i]   = x_q[i] - speed_s;
            retire_s[i] = act_q[i] && ((sext9(x_mv_s[i]) + OBS_W_C) <= 14'sd0);
            free_s[i]   = !act_q[i] || retire_s[i];
            ret_cnt_s   = ret_cnt_s + {3'd0, retire_s[i]};
        end
        spawn_oh_s  = free_s & (~free_s + NUM_OBS'(1));
        score_sum_s = {1'b0, score_q} + {5'd0, ret_cnt_s};
        cnt_inc_s   = cnt_q + CNT_W'(1);
        spawn_h_s   = 4'd4 + {1'b0, lfsr_q[1:0], 1'b0};
    end

    // Slot, score and spawn-counter next state; a slot freed this tick may be reused at once.
    always_comb begin
        act_d   = act_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < NUM_OBS; i++) begin
            x_d[i] = x_q[i];
            h_d[i] = h_q[i];
        end
        if (!game_active || (state_q == ST_IDLE)) begin
            act_d   = '0;
            score_d = 8'd0;
            cnt_d   = '0;
        end else if ((state_q == ST_RUN) && !is_collision && frame_tick) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (act_q[i]) begin
                    x_d[i]   = x_mv_s[i];
                    act_d[i] = !retire_s[i];
                end else begin
                    act_d[i] = 1'b0;
                end
            end
            score_d = score_sum_s[8] ? 8'hFF : score_sum_s[7:0];
            if (cnt_inc_s >= GAP_C) begin
                if (|free_s) begin
                    for (int i = 0; i < NUM_OBS; i++) begin
                        if (spawn_oh_s[i]) begin
                            act_d[i] = 1'b1;
                            x_d[i]   = SPAWN_X_C;
                            h_d[i]   = spawn_h_s;
                        end else begin
                            h_d[i]   = h_d[i];
                        end
                    end
                    cnt_d = '0;
                end else begin
                    cnt_d = GAP_C;
                end
            end else begin
                cnt_d = cnt_inc_s;
            end
        end else begin
            act_d = act_q;
        end
    end

    // Height LFSR free-runs only while the game is running.
    always_comb begin
        if (state_q == ST_RUN) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Pixel decode and signed hit test; off-screen slot parts clip naturally.
    always_comb begin
        px_u_s = pixel_index % SCREEN_W_C;
        py_u_s = pixel_index / SCREEN_W_C;
        px_s   = $signed({1'b0, px_u_s});
        py_s   = $signed({1'b0, py_u_s});
        for (int i = 0; i < NUM_OBS; i++) begin
            hit_vec_s[i] = act_q[i]
                        && (px_s >= sext9(x_q[i]))
                        && (px_s <  (sext9(x_q[i]) + OBS_W_C))
                        && (py_s >= (GROUND_C - $signed({10'd0, h_q[i]})))
                        && (py_s <  GROUND_C);
        end
        hit_d = game_active && (state_q != ST_IDLE) && (pixel_index < PIX_MAX_C) && (|hit_vec_s);
    end

    // Datapath registers.
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            act_q   <= '0;
            score_q <= 8'd0;
            cnt_q   <= '0;
            lfsr_q  <= 8'hA5;
            hit_q   <= 1'b0;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i] <= 9'sd0;
                h_q[i] <= 4'd0;
            end
        end else begin
            act_q   <= act_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            hit_q   <= hit_d;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i] <= x_d[i];
                h_q[i] <= h_d[i];
            end
        end
    end

    assign is_obstacle_hitbox = hit_q;
    assign score              = score_q;
    assign game_frozen        = frozen_s;

endmodule

// File: tb/tb_obstacle_hitbox_gen.sv
// Directed bench for obstacle_hitbox_gen. dut_a uses default parameters;
// dut_b shares all inputs but spawns every 20 frames so all four slots fill.
module tb_obstacle_hitbox_gen;
    logic        clock_100mhz = 1'b0;
    logic        reset_n      = 1'b1;
    logic [12:0] pixel_index  = 13'd0;
    logic        frame_tick   = 1'b0;
    logic        game_active  = 1'b0;
    logic        is_collision = 1'b0;
    logic        hit_a, hit_b, frz_a, frz_b;
    logic [7:0]  score_a, score_b;

    int          total = 0;
    int          bad   = 0;
    int          t_run = 0;
    logic [7:0]  m_lfsr;
    int          m_st;
    logic [7:0]  last_lfsr;
    int          h_a0;
    logic        ha, hb;

    always #5 clock_100mhz = ~clock_100mhz;

    obstacle_hitbox_gen dut_a (
        .clock_100mhz(clock_100mhz), .reset_n(reset_n), .pixel_index(pixel_index),
        .frame_tick(frame_tick), .game_active(game_active), .is_collision(is_collision),
        .is_obstacle_hitbox(hit_a), .score(score_a), .game_frozen(frz_a)
    );

    obstacle_hitbox_gen #(.SPAWN_GAP(20)) dut_b (
        .clock_100mhz(clock_100mhz), .reset_n(reset_n), .pixel_index(pixel_index),
        .frame_tick(frame_tick), .game_active(game_active), .is_collision(is_collision),
        .is_obstacle_hitbox(hit_b), .score(score_b), .game_frozen(frz_b)
    );

    // Reference LFSR: 0=IDLE 1=RUN 2=FROZEN; advances each clock spent in RUN.
    always @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            m_st   <= 0;
            m_lfsr <= 8'hA5;
        end else begin
            if (m_st == 1) m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            if (!game_active) m_st <= 0;
            else if (m_st == 0) m_st <= 1;
            else if ((m_st == 1) && is_collision) m_st <= 2;
        end
    end

    function automatic int pix(input int x, input int y);
        return y * 96 + x;
    endfunction

    task automatic tick();
        @(negedge clock_100mhz);
        frame_tick = 1'b1;
        last_lfsr  = m_lfsr;
        @(negedge clock_100mhz);
        frame_tick = 1'b0;
        t_run++;
    endtask

    task automatic tick_to(input int n);
        while (t_run < n) tick();
    endtask

    task automatic probe(input int idx, output logic pa, output logic pb);
        @(negedge clock_100mhz);
        pixel_index = 13'(idx);
        @(negedge clock_100mhz);
        pa = hit_a;
        pb = hit_b;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #20;
        total++; if (score_a !== 8'd0) begin bad++; $display("FAIL rst_score got=%0d want=0", score_a); end
        total++; if (frz_a !== 1'b0) begin bad++; $display("FAIL rst_frozen got=%b want=0", frz_a); end
        total++; if (hit_a !== 1'b0) begin bad++; $display("FAIL rst_hit got=%b want=0", hit_a); end
        @(negedge clock_100mhz);
        reset_n = 1'b1;
        repeat (2) @(negedge clock_100mhz);
        total++; if (score_b !== 8'd0 || frz_b !== 1'b0) begin bad++; $display("FAIL rst_b got=%0d/%b want=0/0", score_b, frz_b); end
    endtask

    task automatic test_spawn();
        int nz;
        @(negedge clock_100mhz);
        game_active = 1'b1;
        @(negedge clock_100mhz);
        tick_to(40);
        h_a0 = 4 + 2 * int'(last_lfsr[1:0]);
        total++; if (score_a !== 8'd0) begin bad++; $display("FAIL spawn_score got=%0d want=0", score_a); end
        nz = 0;
        for (int p = 0; p < 6144; p++) begin
            probe(p, ha, hb);
            if (ha !== 1'b0) nz++;
        end
        total++; if (nz != 0) begin bad++; $display("FAIL spawn_scan hits=%0d want=0", nz); end
    endtask

    task automatic test_move();
        tick_to(50);
        probe(pix(88, 55), ha, hb);
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL move_88 got=%b want=1", ha); end
        probe(pix(92, 55), ha, hb);
        total++; if (ha !== 1'b0) begin bad++; $display("FAIL move_92 got=%b want=0", ha); end
        probe(pix(86, 55), ha, hb);
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL move_86 got=%b want=1", ha); end
        probe(pix(85, 55), ha, hb);
        total++; if (ha !== 1'b0) begin bad++; $display("FAIL move_85 got=%b want=0", ha); end
        probe(pix(91, 55), ha, hb);
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL move_91 got=%b want=1", ha); end
        probe(pix(88, 56 - h_a0), ha, hb);
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL height_top h=%0d got=%b want=1", h_a0, ha); end
        probe(pix(88, 55 - h_a0), ha, hb);
        total++; if (ha !== 1'b0) begin bad++; $display("FAIL height_above h=%0d got=%b want=0", h_a0, ha); end
        probe(8191, ha, hb);
        total++; if (ha !== 1'b0) begin bad++; $display("FAIL out_of_range got=%b want=0", ha); end
    endtask

    task automatic test_fill();
        tick_to(121);
        probe(pix(95, 55), ha, hb);
        total++; if (hb !== 1'b0) begin bad++; $display("FAIL fill_no_fifth got=%b want=0", hb); end
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL a_third_spawn got=%b want=1", ha); end
        total++; if (score_b !== 8'd0) begin bad++; $display("FAIL fill_score121 got=%0d want=0", score_b); end
        tick_to(122);
        total++; if (score_b !== 8'd1) begin bad++; $display("FAIL fill_score122 got=%0d want=1", score_b); end
        probe(pix(95, 55), ha, hb);
        total++; if (hb !== 1'b0) begin bad++; $display("FAIL fill_spawn_x96 got=%b want=0", hb); end
        tick_to(123);
        probe(pix(95, 55), ha, hb);
        total++; if (hb !== 1'b1) begin bad++; $display("FAIL fill_respawn got=%b want=1", hb); end
    endtask

    task automatic test_retire();
        tick_to(141);
        total++; if (score_a !== 8'd0) begin bad++; $display("FAIL retire_pre_score got=%0d want=0", score_a); end
        probe(pix(0, 55), ha, hb);
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL retire_pre_edge got=%b want=1", ha); end
        tick_to(142);
        total++; if (score_a !== 8'd1) begin bad++; $display("FAIL retire_score got=%0d want=1", score_a); end
        total++; if (score_b !== 8'd2) begin bad++; $display("FAIL retire_score_b got=%0d want=2", score_b); end
        probe(pix(0, 55), ha, hb);
        total++; if (ha !== 1'b0) begin bad++; $display("FAIL retire_edge got=%b want=0", ha); end
        tick_to(143);
        probe(pix(95, 55), ha, hb);
        total++; if (hb !== 1'b1) begin bad++; $display("FAIL hold_respawn got=%b want=1", hb); end
    endtask

    task automatic test_freeze();
        probe(pix(33, 55), ha, hb);
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL pre_freeze got=%b want=1", ha); end
        @(negedge clock_100mhz);
        frame_tick   = 1'b1;
        is_collision = 1'b1;
        @(negedge clock_100mhz);
        frame_tick   = 1'b0;
        total++; if (frz_a !== 1'b1 || frz_b !== 1'b1) begin bad++; $display("FAIL frozen got=%b/%b want=1/1", frz_a, frz_b); end
        probe(pix(32, 55), ha, hb);
        total++; if (ha !== 1'b0) begin bad++; $display("FAIL freeze_no_move got=%b want=0", ha); end
        repeat (5) begin
            @(negedge clock_100mhz);
            frame_tick = 1'b1;
            @(negedge clock_100mhz);
            frame_tick = 1'b0;
        end
        probe(pix(33, 55), ha, hb);
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL freeze_drawn got=%b want=1", ha); end
        probe(pix(38, 55), ha, hb);
        total++; if (ha !== 1'b1) begin bad++; $display("FAIL freeze_right got=%b want=1", ha); end
        probe(pix(39, 55), ha, hb);
        total++; if (ha !== 1'b0) begin bad++; $display("FAIL freeze_past got=%b want=0", ha); end
        total++; if (score_a !== 8'd1 || score_b !== 8'd2) begin bad++; $display("FAIL freeze_score got=%0d/%0d want=1/2", score_a, score_b); end
        total++; if (frz_a !== 1'b1) begin bad++; $display("FAIL freeze_hold got=%b want=1", frz_a); end
    endtask

    task automatic test_idle();
        @(negedge clock_100mhz);
        pixel_index  = 13'(pix(33, 55));
        @(negedge clock_100mhz);
        game_active  = 1'b0;
        is_collision = 1'b0;
        @(negedge clock_100mhz);
        total++; if (score_a !== 8'd0 || score_b !== 8'd0) begin bad++; $display("FAIL idle_score got=%0d/%0d want=0/0", score_a, score_b); end
        total++; if (frz_a !== 1'b0) begin bad++; $display("FAIL idle_frozen got=%b want=0", frz_a); end
        total++; if (hit_a !== 1'b0) begin bad++; $display("FAIL idle_hit got=%b want=0", hit_a); end
    endtask

    task automatic test_async_reset();
        @(negedge clock_100mhz);
        game_active = 1'b1;
        @(negedge clock_100mhz);
        t_run = 0;
        tick_to(41);
        probe(pix(95, 55), ha, hb);
        total++; if (ha !== 1'b1 || hb !== 1'b1) begin bad++; $display("FAIL rerun_hit got=%b/%b want=1/1", ha, hb); end
        @(posedge clock_100mhz);
        #2 reset_n = 1'b0;
        #1;
        total++; if (hit_a !== 1'b0 || hit_b !== 1'b0) begin bad++; $display("FAIL async_hit got=%b/%b want=0/0", hit_a, hit_b); end
        total++; if (score_a !== 8'd0 || frz_a !== 1'b0) begin bad++; $display("FAIL async_state got=%0d/%b want=0/0", score_a, frz_a); end
        @(negedge clock_100mhz);
        reset_n = 1'b1;
        repeat (3) @(negedge clock_100mhz);
        total++; if (hit_a !== 1'b0) begin bad++; $display("FAIL post_reset_hit got=%b want=0", hit_a); end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_move();
        test_fill();
        test_retire();
        test_freeze();
        test_idle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/obstacle_hitbox_gen.md
Name: obstacle_hitbox_gen

Overview:
- Produces `is_obstacle_hitbox` for the current OLED pixel. This is the signal that the collision detector consumes.
- Owns up to NUM_OBS ground obstacles:
  - spawns them at the right edge using an LFSR-chosen height;
  - scrolls them left once per frame;
  - retires them off the left edge and counts score.
- Freezes the scene when `is_collision` is asserted. Sits between the frame/pixel timing logic and the collision detector.

Parameters:
- NUM_OBS, 4, number of obstacle slots (1..8).
- SCREEN_W, 96, display width in pixels.
- SCREEN_H, 64, display height in pixels.
- OBS_W, 6, obstacle width in pixels.
- GROUND_Y, 56, first row below the ground line; obstacles occupy rows [GROUND_Y-h, GROUND_Y-1].
- SPAWN_GAP, 40, minimum number of frames between spawns.
- BASE_SPEED, 1, pixels moved per frame_tick.

Ports:
- clock_100mhz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pixel_index  in  13  current pixel, row-major (x = index mod SCREEN_W, y = index div SCREEN_W).
- frame_tick  in  1  one-cycle pulse per frame, at frame end.
- game_active  in  1  high while a game is running.
- is_collision  in  1  sticky collision flag from the collision detector.
- is_obstacle_hitbox  out  1  current pixel lies inside an active obstacle.
- score  out  8  number of obstacles cleared, saturating at 255.
- game_frozen  out  1  high while in the FROZEN state.

Behaviour:
- Reset is asynchronous and active-low; clock is clock_100mhz only. On reset:
  - all slots inactive;
  - state=IDLE;
  - score=0;
  - is_obstacle_hitbox=0;
  - game_frozen=0;
  - spawn counter=0;
  - LFSR=8'hA5.
- Per slot: active bit, x (signed 9-bit), h (4-bit).
- FSM:
  - IDLE: slots held inactive, score held at 0. Goes to RUN on game_active=1.
  - RUN: on each frame_tick, every active slot does x <= x - speed. A slot whose new x+OBS_W <= 0 becomes inactive and score increments by 1 (saturating). Multiple retirements on the same tick add their count.
  - RUN spawn: the spawn counter increments on each frame_tick. When counter >= SPAWN_GAP and at least one slot is free, the lowest-index free slot becomes active in that same tick with x=SCREEN_W and h = 4 + 2*LFSR[1:0] (4,6,8,10), and the counter clears. If no slot is free, the counter holds at SPAWN_GAP until one frees.
  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, advanced every clock in RUN.
  - RUN -> FROZEN on is_collision=1. is_collision takes priority over a coincident frame_tick: no movement on that tick.
  - FROZEN: positions, score and LFSR held. game_frozen=1. Hitbox output continues so the scene stays drawn.
  - Any state -> IDLE on game_active=0. Takes priority over all other events; slots clear and score clears on the next clock.
- Hitbox:
  - A pixel (px,py) is inside a slot when the slot is active, x <= px < x+OBS_W, and GROUND_Y-h <= py < GROUND_Y.
  - Comparisons are signed, so slots partially off-screen left or right are clipped naturally.
  - is_obstacle_hitbox is registered: exactly 1 cycle of latency from pixel_index. It is 0 in IDLE.
- pixel_index >= SCREEN_W*SCREEN_H gives hitbox 0.

Optional Feature:
- Macro: OBSTACLE_SPEEDUP_EN.
- Defined: speed = BASE_SPEED + (score >> 3), capped at BASE_SPEED+3. Speed updates on the tick after the score changes.
- Undefined: speed is constant BASE_SPEED and no speed logic is synthesized.

Test Plan:
- Reset then game_active=1, 40 frame_ticks -> slot0 active at x=96 with h=4+2*LFSR[1:0]. score=0; is_obstacle_hitbox=0 for every pixel.
- After spawn, 10 more frame_ticks at BASE_SPEED=1 -> slot0 x=86. pixel_index=55*96+88 gives is_obstacle_hitbox=1 one cycle later; pixel_index=55*96+92 gives 0.
- Run until slot0 x reaches -6 -> slot0 inactive and score=1. Two slots retiring on the same tick -> score increments by 2.
- Fill all 4 slots, then keep ticking -> no fifth spawn. Spawn counter holds at 40; the next spawn happens on the tick a slot frees.
- Assert is_collision on the same cycle as frame_tick -> no movement, game_frozen=1. Positions and score are unchanged after 5 further ticks; the hitbox is still drawn.
- In FROZEN, drop game_active -> IDLE next clock with score=0 and hitbox 0. Pulse reset_n low mid-RUN -> all outputs 0 immediately (asynchronous).
